// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a serialiser with per-frame latched
// line configuration, break generation and FIFO status outputs.
module uart_tx_fifo #(
    parameter int CLOCK_DIVISOR_WIDTH = 24,
    parameter int FIFO_ADDR_WIDTH     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           tx,
    input  logic                           enable,
    input  logic [1:0]                     dataBits,
    input  logic                           hasParity,
    input  logic [1:0]                     parityMode,
    input  logic                           extraStopBit,
    input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
    input  logic                           breakReq,
    input  logic [7:0]                     wrData,
    input  logic                           wrValid,
    output logic                           wrReady,
    output logic                           overflow,
    output logic [FIFO_ADDR_WIDTH:0]       level,
    output logic                           busy,
    output logic                           txDone
);

    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_BREAK_END
    } state_t;

    state_t                         r_state;
    logic [7:0]                     r_mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0]     r_wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0]     r_rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]       r_level;

    logic [7:0]                     r_data;
    logic [2:0]                     r_last_bit;
    logic                           r_has_par;
    logic [1:0]                     r_par_mode;
    logic                           r_extra_stop;
    logic [CLOCK_DIVISOR_WIDTH-1:0] r_div;
    logic [CLOCK_DIVISOR_WIDTH-1:0] r_cnt;
    logic [2:0]                     r_bit_idx;
    logic                           r_second_stop;
    logic                           r_tx;
    logic                           r_done;

    logic                           w_full;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_bit_end;
    logic [7:0]                     w_mask;
    logic                           w_par;

    assign w_full    = (r_level == (FIFO_ADDR_WIDTH+1)'(DEPTH));
    assign w_push    = wrValid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !breakReq && enable && (r_level != '0);
    assign w_bit_end = (r_cnt == r_div);
    assign w_mask    = 8'hFF >> (3'd3 - {1'b0, dataBits});

    // Unused high data bits are cleared at pop, so parity is a plain reduction.
    always_comb begin
        w_par = 1'b0;
        case (r_par_mode)
            2'b00:   w_par = 1'b0;
            2'b11:   w_par = 1'b1;
            2'b10:   w_par = ^r_data;
            default: w_par = ~^r_data;
        endcase
    end

    assign tx       = r_tx;
    assign txDone   = r_done;
    assign busy     = (r_state != S_IDLE);
    assign wrReady  = !w_full;
    assign overflow = wrValid && w_full;
    assign level    = r_level;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wrData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tx          <= 1'b1;
            r_done        <= 1'b0;
            r_cnt         <= '0;
            r_div         <= '0;
            r_bit_idx     <= '0;
            r_second_stop <= 1'b0;
            r_data        <= '0;
            r_last_bit    <= '0;
            r_has_par     <= 1'b0;
            r_par_mode    <= '0;
            r_extra_stop  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Bit-period counter free-runs 0..D; IDLE and BREAK hold it at zero.
            if (w_bit_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                    if (breakReq) begin
                        r_state <= S_BREAK;
                        r_tx    <= 1'b0;
                    end else if (w_pop) begin
                        r_data       <= r_mem[r_rd_ptr] & w_mask;
                        r_last_bit   <= {1'b0, dataBits} + 3'd4;
                        r_has_par    <= hasParity;
                        r_par_mode   <= parityMode;
                        r_extra_stop <= extraStopBit;
                        r_div        <= clockDivisor;
                        r_tx         <= 1'b0;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_data[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == r_last_bit) begin
                            r_second_stop <= 1'b0;
                            if (r_has_par) begin
                                r_state <= S_PARITY;
                                r_tx    <= w_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_data[r_bit_idx + 3'd1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state       <= S_STOP;
                        r_second_stop <= 1'b0;
                        r_tx          <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_extra_stop && !r_second_stop) begin
                            r_second_stop <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    r_cnt <= '0;
                    if (!breakReq) begin
                        r_state <= S_BREAK_END;
                        r_div   <= clockDivisor;
                        r_tx    <= 1'b1;
                    end
                end
                S_BREAK_END: begin
                    if (w_bit_end)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: pushes are mirrored into a scoreboard and a
// line monitor rebuilds each expected frame cycle by cycle from the entry popped.
module tb_uart_tx_fifo;

    localparam int CDW = 24;
    localparam int FAW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           tx;
    logic           enable = 1'b0;
    logic [1:0]     dataBits = 2'd3;
    logic           hasParity = 1'b0;
    logic [1:0]     parityMode = 2'b00;
    logic           extraStopBit = 1'b0;
    logic [CDW-1:0] clockDivisor = '0;
    logic           breakReq = 1'b0;
    logic [7:0]     wrData = 8'h00;
    logic           wrValid = 1'b0;
    logic           wrReady;
    logic           overflow;
    logic [FAW:0]   level;
    logic           busy;
    logic           txDone;

    uart_tx_fifo #(.CLOCK_DIVISOR_WIDTH(CDW), .FIFO_ADDR_WIDTH(FAW)) dut (
        .clk(clk), .rst(rst), .tx(tx), .enable(enable), .dataBits(dataBits),
        .hasParity(hasParity), .parityMode(parityMode), .extraStopBit(extraStopBit),
        .clockDivisor(clockDivisor), .breakReq(breakReq), .wrData(wrData),
        .wrValid(wrValid), .wrReady(wrReady), .overflow(overflow), .level(level),
        .busy(busy), .txDone(txDone)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]     d;
        logic [1:0]     nb;
        logic           hp;
        logic [1:0]     pm;
        logic           s2;
        logic [CDW-1:0] div;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   frames_done = 0;
    int   done_cyc = 0;
    int   cyc = 0;
    bit   mon_on = 1'b0;
    bit   brk_ok = 1'b0;
    bit   lvl_chk = 1'b0;
    bit   b2b_chk = 1'b0;
    bit   have_prev = 1'b0;
    logic prev_tx = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; accepted bytes enter the scoreboard.
    task automatic push(input logic [7:0] d, input logic acc);
        ent_t e;
        wrData  = d;
        wrValid = 1'b1;
        @(negedge clk);
        chk("wrReady", wrReady, acc);
        chk("overflow", overflow, !acc);
        if (acc) begin
            e = '{d, dataBits, hasParity, parityMode, extraStopBit, clockDivisor};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        wrValid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("frame_count", frames_done, target);
        #1;
    endtask

    task automatic check_frame();
        ent_t       e;
        logic [7:0] m;
        logic       p;
        logic       bits [12];
        int         nb;
        int         len;
        if (sb.size() == 0 && brk_ok) return;
        chk("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (lvl_chk) chk("level_at_pop", level, sb.size());
        if (b2b_chk && have_prev) chk("b2b_gap", cyc - done_cyc, 1);
        nb = int'(e.nb) + 5;
        m  = e.d & 8'((1 << nb) - 1);
        case (e.pm)
            2'b00:   p = 1'b0;
            2'b11:   p = 1'b1;
            2'b10:   p = ^m;
            default: p = ~^m;
        endcase
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1+i] = m[i];
        len = 1 + nb;
        if (e.hp) begin bits[len] = p; len++; end
        bits[len] = 1'b1; len++;
        if (e.s2) begin bits[len] = 1'b1; len++; end
        for (int b = 0; b < len; b++) begin
            for (int c = 0; c <= int'(e.div); c++) begin
                if (b != 0 || c != 0) begin
                    @(negedge clk);
                    if (rst) begin sb.delete(); return; end
                end
                chk($sformatf("tx_bit%0d", b), tx, bits[b]);
                chk("busy_frame", busy, 1'b1);
                chk("txDone_early", txDone, 1'b0);
            end
        end
        @(negedge clk);
        if (rst) begin sb.delete(); return; end
        chk("txDone_pulse", txDone, 1'b1);
        chk("tx_after_frame", tx, 1'b1);
        chk("busy_after_frame", busy, 1'b0);
        frames_done++;
        done_cyc  = cyc;
        have_prev = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on && rst === 1'b0 && tx === 1'b0 && prev_tx === 1'b1) check_frame();
            prev_tx = tx;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_level", level, 0);
        chk("rst_wrReady", wrReady, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_txDone", txDone, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_on = 1'b1;

        // 8N1, D=3, single byte
        clockDivisor = 3; dataBits = 2'd3; hasParity = 0; extraStopBit = 0;
        enable = 1'b1;
        push(8'hA5, 1'b1);
        wait_done(1, 100);

        // 7 data bits, odd parity, 2 stop, D=1
        clockDivisor = 1; dataBits = 2'd2; hasParity = 1; parityMode = 2'b01; extraStopBit = 1;
        push(8'h55, 1'b1);
        wait_done(2, 100);

        // even parity; config scrambled mid-frame must not matter
        parityMode = 2'b10;
        push(8'h55, 1'b1);
        @(posedge clk); #1;
        chk("busy_after_pop", busy, 1'b1);
        dataBits = 2'd0; hasParity = 0; clockDivisor = 5; parityMode = 2'b11; extraStopBit = 0;
        wait_done(3, 100);

        // D=0, 5 data bits, mark parity, back-to-back
        enable = 1'b0;
        clockDivisor = 0; dataBits = 2'd0; hasParity = 1; parityMode = 2'b11; extraStopBit = 0;
        push(8'hFF, 1'b1);
        push(8'h00, 1'b1);
        push(8'h13, 1'b1);
        have_prev = 1'b0; b2b_chk = 1'b1;
        enable = 1'b1;
        wait_done(6, 100);
        b2b_chk = 1'b0;

        // fill to full, overflow, then enable rises with a rejected push
        enable = 1'b0;
        clockDivisor = 1; dataBits = 2'd3; hasParity = 0; extraStopBit = 0;
        for (int i = 0; i < 16; i++) push(8'((i * 37) ^ 8'h3C), 1'b1);
        chk("level_full", level, 16);
        chk("wrReady_full", wrReady, 1'b0);
        push(8'hEE, 1'b0);
        chk("level_after_ovf", level, 16);
        wrData = 8'h77; wrValid = 1'b1;
        have_prev = 1'b0; b2b_chk = 1'b1; lvl_chk = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        chk("ovf_at_pop", overflow, 1'b1);
        chk("wrReady_at_pop", wrReady, 1'b0);
        @(posedge clk); #1;
        wrValid = 1'b0;
        chk("level_16_to_15", level, 15);
        wait_done(22, 16 * 25 + 50);
        lvl_chk = 1'b0; b2b_chk = 1'b0;
        chk("sb_drained", sb.size(), 0);

        // break while idle, D=7, with a byte queued during the break
        clockDivisor = 7;
        mon_on = 1'b0;
        breakReq = 1'b1;
        push(8'h3A, 1'b1);
        repeat (49) begin
            @(negedge clk);
            chk("break_low", tx, 1'b0);
        end
        @(posedge clk); #1;
        breakReq = 1'b0;
        @(negedge clk);
        chk("break_last_low", tx, 1'b0);
        @(posedge clk); #1;
        mon_on = 1'b1;
        chk("break_end_high", tx, 1'b1);
        repeat (7) begin
            @(negedge clk);
            chk("break_end_high", tx, 1'b1);
        end
        wait_done(23, 150);

        // break requested mid-frame is deferred; BREAK_END uses the divisor at exit
        clockDivisor = 2;
        brk_ok = 1'b1;
        push(8'hC3, 1'b1);
        @(posedge clk); #1;
        breakReq = 1'b1;
        tgt = 24;
        wait_done(tgt, 100);
        @(negedge clk);
        chk("deferred_break_tx", tx, 1'b0);
        chk("deferred_break_busy", busy, 1'b1);
        clockDivisor = 4;
        @(posedge clk); #1;
        breakReq = 1'b0;
        @(negedge clk);
        chk("break2_low", tx, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("break2_end_tx", tx, 1'b1);
            chk("break2_end_busy", busy, 1'b1);
        end
        @(negedge clk);
        chk("break2_idle", busy, 1'b0);
        brk_ok = 1'b0;

        // reset in the middle of DATA with three bytes still queued
        @(posedge clk); #1;
        enable = 1'b0;
        clockDivisor = 3; dataBits = 2'd3; hasParity = 0; extraStopBit = 0;
        for (int i = 0; i < 4; i++) push(8'(8'h81 + i), 1'b1);
        enable = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("level_pre_rst", level, 3);
        chk("busy_pre_rst", busy, 1'b1);
        @(negedge clk);
        sb.delete();
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_level", level, 0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_txDone", txDone, 1'b0);
        chk("rst_mid_wrReady", wrReady, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        tgt = frames_done;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_tx", tx, 1'b1);
            chk("post_rst_txDone", txDone, 1'b0);
        end
        chk("no_frame_after_rst", frames_done, tgt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter: byte FIFO, per-frame latched line configuration (5–8 data bits, parity, 1/2 stop bits, divisor), break generation and status/handshake outputs. Sits between the register/command interface and the `tx` pin; software pushes bytes and the block serialises them back-to-back without per-byte handshaking.

## Interface
- CLOCK_DIVISOR_WIDTH, 24, width of `clockDivisor`; bit period = `clockDivisor`+1 clk cycles
- FIFO_ADDR_WIDTH, 4, FIFO depth = 2^FIFO_ADDR_WIDTH entries (default 16)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- tx  out  1  serial line, idle high
- enable  in  1  frames may start only while high; an in-flight frame always completes
- dataBits  in  2  data bit count = dataBits+5
- hasParity  in  1  insert parity bit
- parityMode  in  2  00 space, 11 mark, 10 even, 01 odd
- extraStopBit  in  1  2 stop bits when high
- clockDivisor  in  CLOCK_DIVISOR_WIDTH  bit period minus one
- breakReq  in  1  level request to hold line low
- wrData  in  8  byte to enqueue
- wrValid  in  1  push request
- wrReady  out  1  !full
- overflow  out  1  1-cycle pulse: wrValid while full (byte dropped)
- level  out  FIFO_ADDR_WIDTH+1  entries queued (excludes the frame being sent)
- busy  out  1  state != IDLE
- txDone  out  1  1-cycle pulse at end of each data frame's last stop bit

## Operation
- FIFO: push accepted iff wrValid && !full. Pop only from IDLE. Push and pop in the same cycle are both honoured; level += push − pop. Full = level == 2^FIFO_ADDR_WIDTH. Pointers wrap modulo depth.
- States: IDLE, START, DATA, PARITY, STOP, BREAK, BREAK_END.
- IDLE, priority order: breakReq → BREAK, tx<=0. Else enable && level>0 → pop head, latch data, dataBits, hasParity, parityMode, extraStopBit, clockDivisor; tx<=0; → START. Else tx stays 1.
- Bit counter counts 0..D (D = latched divisor); each bit lasts D+1 cycles; tx and state change only on the edge where counter == D.
- START → DATA, tx<=data[0]. DATA: LSB first, dataBits+5 bits, unused high bits ignored. Last data bit → PARITY if hasParity, else STOP.
- Parity: even = XOR of the used data bits; odd = inverse; space 0; mark 1.
- STOP: tx=1 for 1 bit period, or 2 if extraStopBit. At the end → IDLE with txDone=1 for that cycle.
- BREAK: tx=0 while breakReq is high; it is sampled each cycle. When breakReq is low → BREAK_END, tx=1 for one bit period using the current clockDivisor, latched on entry. Then → IDLE. breakReq during a frame is deferred until IDLE.
- Input config changes mid-frame have no effect until the next pop.

## Timing
- Reset: tx=1, state IDLE, FIFO emptied (level=0), wrReady=1, overflow=0, busy=0, txDone=0, counters 0. Reset mid-frame aborts the frame; tx=1 the cycle after the reset edge.
- Push latency: byte pushed at edge N is visible in level at N+1. It can be popped at edge N+1, with tx low from N+1.
- Frame length, edge-to-edge: (D+1)·(1 + dataBits+5 + hasParity + 1 + extraStopBit) cycles from the pop edge to the txDone edge.
- Back-to-back: after a txDone edge the block spends exactly 1 cycle in IDLE (tx=1), then pops the next entry. Gap = 1 clk plus stop bits.
- D=0 is legal: 1 cycle per bit.
- overflow is combinational on registered state, coincident with the rejected wrValid cycle.

## Test plan
- D=3, 8N1, push 0xA5, enable=1 → tx low 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high. txDone pulses 40 cycles after the pop edge. busy=1 throughout.
- D=1, 7 data bits, odd parity, 2 stop, push 0x55 → data 1,0,1,0,1,0,1, parity 1, two stop bits. Frame = 22 cycles. The even-parity variant sends parity 0.
- enable=0, push 17 bytes → level=16, wrReady=0, 17th push gives overflow pulse and is dropped. Raise enable → 16 frames in FIFO order, each separated by 1 idle clk, level decrements at each pop.
- Push while full in the same cycle as a pop (enable rising at full) → push still rejected (wrReady=0), level 16→15.
- breakReq high 50 cycles while idle, D=7 → tx low exactly while breakReq is high. Then 8 cycles high, then a queued byte starts. breakReq asserted mid-frame → frame completes first.
- Assert rst in the middle of DATA with 3 bytes queued → tx=1 next cycle, level=0, busy=0, no txDone.
